// File: rtl/div_share_arb.sv
// div_share_arb: round-robin scheduler that shares one 16-bit sequential
// divider among NREQ requesters.
//
// Optional feature macro: DIV_ZERO_BYPASS_EN. When defined, a divide-by-zero
// request is answered directly (rsp_data=16'hFFFF, rsp_err=1). The divider is
// not started for that request.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req[NREQ]       level request per client, held until its gnt bit is seen
//   a_in, b_in      per-client dividend / divisor, slice i = [16*i +: 16]
//   gnt[NREQ]       one-hot pulse, operands of client i captured
//   rsp_valid[NREQ] one-hot pulse, rsp_data valid for client i
//   rsp_data        quotient, held until the next response
//   rsp_err         divide-by-zero flag (bypass feature only, else 0)
//   div_init        divider start pulse
//   div_a, div_b    latched operands, stable from LAUNCH through RESP
//   div_result      divider quotient
//   div_done        divider done (level, may stay high between ops)
//   busy            high whenever the FSM is not in IDLE
module div_share_arb #(
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*16-1:0] a_in,
    input  logic [NREQ*16-1:0] b_in,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [15:0]        rsp_data,
    output logic               rsp_err,
    output logic               div_init,
    output logic [15:0]        div_a,
    output logic [15:0]        div_b,
    input  logic [15:0]        div_result,
    input  logic               div_done,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, owner, win;
    logic            win_vld;
    logic            done_armed;
    int              idx;

    // First requester after ptr, wrapping modulo NREQ.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = PW'(idx);
            end
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    logic win_zero;
    assign win_zero = (b_in[16*win +: 16] == 16'd0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (win_vld) begin
`ifdef DIV_ZERO_BYPASS_EN
                    state_nx = win_zero ? RESP : LAUNCH;
`else
                    state_nx = LAUNCH;
`endif
                end
            end
            LAUNCH: state_nx = WAIT;
            // Only a done that rises after having been seen low belongs to
            // this operation; a done still high from the last op is stale.
            WAIT:   if (div_done && done_armed) state_nx = RESP;
            RESP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign div_init = (state == LAUNCH);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= PW'(NREQ - 1);
            owner      <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            div_a      <= '0;
            div_b      <= '0;
            done_armed <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner <= win;
                        div_a <= a_in[16*win +: 16];
                        div_b <= b_in[16*win +: 16];
                        gnt   <= NREQ'(1) << win;
`ifdef DIV_ZERO_BYPASS_EN
                        if (win_zero) begin
                            rsp_valid <= NREQ'(1) << win;
                            rsp_data  <= 16'hFFFF;
                            rsp_err   <= 1'b1;
                        end
`endif
                    end
                end
                LAUNCH: done_armed <= 1'b0;
                WAIT: begin
                    if (!div_done) done_armed <= 1'b1;
                    if (div_done && done_armed) begin
                        rsp_data  <= div_result;
                        rsp_valid <= NREQ'(1) << owner;
`ifdef DIV_ZERO_BYPASS_EN
                        rsp_err   <= 1'b0;
`endif
                    end
                end
                RESP: ptr <= owner;
                default: ;
            endcase
        end
    end

`ifndef DIV_ZERO_BYPASS_EN
    assign rsp_err = 1'b0;
`endif

endmodule
